// File: rtl/deadtime_gen_pkg.sv
// deadtime_gen_pkg
//   Shared types and helpers for the half-bridge dead-time generator.
//   dt_state_e : leg state; S_DT_* are the both-gates-off commutation gaps.
//   gate_h/gate_l/gate_dt : decode a state into the gate drive pattern, so
//   the output mapping lives in exactly one place.
package deadtime_gen_pkg;

  typedef enum logic [2:0] {
    S_OFF,
    S_LOW,
    S_DT_RISE,
    S_HIGH,
    S_DT_FALL
  } dt_state_e;

  function automatic logic gate_h(input dt_state_e s);
    return (s == S_HIGH);
  endfunction

  function automatic logic gate_l(input dt_state_e s);
    return (s == S_LOW);
  endfunction

  function automatic logic gate_dt(input dt_state_e s);
    return (s == S_DT_RISE) || (s == S_DT_FALL);
  endfunction

endpackage

// File: rtl/deadtime_gen.sv
// deadtime_gen
//   Turns a single-ended pwm signal into a complementary high-side/low-side
//   gate pair with a programmable both-off gap at every commutation, and
//   forces both gates off whenever the leg is disabled.
//
//   Build option: DEADTIME_ASYM_EN
//     defined   : separate dt_rise (gap before pwm_h) and dt_fall (gap before
//                 pwm_l) ports; dead_time is absent.
//     undefined : one dead_time port used for both directions.
//
//   Ports
//     clk        in   rising-edge system clock
//     reset      in   synchronous, active-high
//     enable     in   1 = run, 0 = both gates off next cycle
//     pwm_in     in   1 = high side requested
//     dead_time  in   DT_W gap length in clk cycles (symmetric build)
//     dt_rise    in   DT_W gap before pwm_h asserts (asymmetric build)
//     dt_fall    in   DT_W gap before pwm_l asserts (asymmetric build)
//     pwm_h      out  high-side gate, registered
//     pwm_l      out  low-side gate, registered
//     dt_active  out  1 while in a dead-time gap, registered
module deadtime_gen
  import deadtime_gen_pkg::*;
#(
  parameter int DT_W = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            enable,
  input  logic            pwm_in,
`ifdef DEADTIME_ASYM_EN
  input  logic [DT_W-1:0] dt_rise,
  input  logic [DT_W-1:0] dt_fall,
`else
  input  logic [DT_W-1:0] dead_time,
`endif
  output logic            pwm_h,
  output logic            pwm_l,
  output logic            dt_active
);

  logic [DT_W-1:0] dt_rise_sel;
  logic [DT_W-1:0] dt_fall_sel;

`ifdef DEADTIME_ASYM_EN
  assign dt_rise_sel = dt_rise;
  assign dt_fall_sel = dt_fall;
`else
  assign dt_rise_sel = dead_time;
  assign dt_fall_sel = dead_time;
`endif

  dt_state_e       state;
  dt_state_e       state_nxt;
  logic [DT_W-1:0] cnt;
  logic [DT_W-1:0] cnt_nxt;

  // Next-state logic. The gap length is captured into cnt only on entry to a
  // dead-time state, so later changes of the dt inputs do not disturb a gap
  // already in progress. A zero gap skips the dead-time state entirely; the
  // counter is loaded with dt-1 so that the gap lasts exactly dt cycles.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (!enable) begin
      state_nxt = S_OFF;
      cnt_nxt   = '0;
    end else begin
      unique case (state)
        S_OFF: begin
          if (pwm_in) begin
            if (dt_rise_sel == '0) begin
              state_nxt = S_HIGH;
            end else begin
              state_nxt = S_DT_RISE;
              cnt_nxt   = dt_rise_sel - DT_W'(1);
            end
          end else begin
            if (dt_fall_sel == '0) begin
              state_nxt = S_LOW;
            end else begin
              state_nxt = S_DT_FALL;
              cnt_nxt   = dt_fall_sel - DT_W'(1);
            end
          end
        end
        S_LOW: begin
          if (pwm_in) begin
            if (dt_rise_sel == '0) begin
              state_nxt = S_HIGH;
            end else begin
              state_nxt = S_DT_RISE;
              cnt_nxt   = dt_rise_sel - DT_W'(1);
            end
          end
        end
        S_HIGH: begin
          if (!pwm_in) begin
            if (dt_fall_sel == '0) begin
              state_nxt = S_LOW;
            end else begin
              state_nxt = S_DT_FALL;
              cnt_nxt   = dt_fall_sel - DT_W'(1);
            end
          end
        end
        // A pwm pulse shorter than the gap is swallowed: fall back to the
        // gate that was on before the commutation started.
        S_DT_RISE: begin
          if (!pwm_in) begin
            state_nxt = S_LOW;
            cnt_nxt   = '0;
          end else if (cnt == '0) begin
            state_nxt = S_HIGH;
          end else begin
            cnt_nxt = cnt - DT_W'(1);
          end
        end
        S_DT_FALL: begin
          if (pwm_in) begin
            state_nxt = S_HIGH;
            cnt_nxt   = '0;
          end else if (cnt == '0) begin
            state_nxt = S_LOW;
          end else begin
            cnt_nxt = cnt - DT_W'(1);
          end
        end
        default: begin
          state_nxt = S_OFF;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  // Gate outputs are decoded from the next state and registered alongside
  // it, so the pins change on the same edge as the state and never glitch.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_OFF;
      cnt       <= '0;
      pwm_h     <= 1'b0;
      pwm_l     <= 1'b0;
      dt_active <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      pwm_h     <= gate_h(state_nxt);
      pwm_l     <= gate_l(state_nxt);
      dt_active <= gate_dt(state_nxt);
    end
  end

endmodule

// File: tb/tb_deadtime_gen.sv
// tb_deadtime_gen
//   Scoreboard bench for deadtime_gen. The stimulus process drives inputs on
//   the falling edge and pushes the gate pattern expected after the next
//   rising edge; a monitor pops and compares one entry per cycle.
//   The reference model describes the leg by what is conducting and, during
//   a gap, the absolute cycle at which the new gate may turn on.
//   Define DEADTIME_ASYM_EN for the asymmetric build.
module tb_deadtime_gen;

  localparam int DT_W = 16;

  logic            clk = 1'b0;
  logic            reset;
  logic            enable;
  logic            pwm_in;
`ifdef DEADTIME_ASYM_EN
  logic [DT_W-1:0] dt_rise;
  logic [DT_W-1:0] dt_fall;
`else
  logic [DT_W-1:0] dead_time;
`endif
  logic            pwm_h;
  logic            pwm_l;
  logic            dt_active;

  deadtime_gen #(.DT_W(DT_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .pwm_in    (pwm_in),
`ifdef DEADTIME_ASYM_EN
    .dt_rise   (dt_rise),
    .dt_fall   (dt_fall),
`else
    .dead_time (dead_time),
`endif
    .pwm_h     (pwm_h),
    .pwm_l     (pwm_l),
    .dt_active (dt_active)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic h;
    logic l;
    logic d;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: what the leg conducts and when a pending gate turns on.
  localparam int M_OFF = 0, M_LOW = 1, M_HIGH = 2, M_GAP = 3;
  int     m_mode   = M_OFF;
  int     m_target = 0;
  longint m_on_at  = 0;
  longint m_edge   = 0;

  task automatic set_dt(input int r, input int f);
`ifdef DEADTIME_ASYM_EN
    dt_rise = DT_W'(r);
    dt_fall = DT_W'(f);
`else
    dead_time = DT_W'(r);
`endif
  endtask

  function automatic int rise_dt();
`ifdef DEADTIME_ASYM_EN
    return int'(dt_rise);
`else
    return int'(dead_time);
`endif
  endfunction

  function automatic int fall_dt();
`ifdef DEADTIME_ASYM_EN
    return int'(dt_fall);
`else
    return int'(dead_time);
`endif
  endfunction

  // Start a commutation towards tgt (1 = high). Gates stay off for d cycles
  // after this edge and the new gate turns on d+1 cycles after it.
  task automatic commutate(input int tgt, input int d);
    if (d == 0) begin
      m_mode = tgt ? M_HIGH : M_LOW;
    end else begin
      m_mode   = M_GAP;
      m_target = tgt;
      m_on_at  = m_edge + d + 1;
    end
  endtask

  task automatic model_step();
    exp_t e;
    if (reset || !enable) begin
      m_mode = M_OFF;
    end else begin
      case (m_mode)
        M_OFF:  commutate(int'(pwm_in), pwm_in ? rise_dt() : fall_dt());
        M_LOW:  if (pwm_in) commutate(1, rise_dt());
        M_HIGH: if (!pwm_in) commutate(0, fall_dt());
        default: begin
          if (int'(pwm_in) != m_target)
            m_mode = pwm_in ? M_HIGH : M_LOW;
          else if (m_edge + 1 >= m_on_at)
            m_mode = m_target ? M_HIGH : M_LOW;
        end
      endcase
    end
    e.h = (m_mode == M_HIGH);
    e.l = (m_mode == M_LOW);
    e.d = (m_mode == M_GAP);
    q.push_back(e);
    m_edge++;
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      model_step();
      @(negedge clk);
    end
  endtask

  // Monitor: one expected pattern per rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() != 0) begin
        e = q.pop_front();
        checks++;
        if ({pwm_h, pwm_l, dt_active} !== e) begin
          errors++;
          $display("FAIL gates @%0t: got h=%b l=%b dt=%b, expected h=%b l=%b dt=%b",
                   $time, pwm_h, pwm_l, dt_active, e.h, e.l, e.d);
        end
        checks++;
        if (pwm_h && pwm_l) begin
          errors++;
          $display("FAIL overlap @%0t: got h=1 l=1, expected never both", $time);
        end
      end
    end
  end

  initial begin
    // Reset held with pwm_in=1, enable=1: everything stays off.
    reset  = 1'b1;
    enable = 1'b1;
    pwm_in = 1'b1;
    set_dt(5, 5);
    tick(3);
    reset = 1'b0;

    // dead_time=5: settle low, then a rising and a falling commutation.
    pwm_in = 1'b0;
    tick(8);
    pwm_in = 1'b1;
    tick(10);
    pwm_in = 1'b0;
    tick(10);

    // dead_time=0: gates swap on every edge without a gap.
    set_dt(0, 0);
    for (int i = 0; i < 8; i++) begin
      pwm_in = ~pwm_in;
      tick(1);
    end
    pwm_in = 1'b0;
    tick(2);

    // dead_time=10: a 4-cycle pulse is swallowed.
    set_dt(10, 10);
    tick(3);
    pwm_in = 1'b1;
    tick(4);
    pwm_in = 1'b0;
    tick(15);

    // Disable in S_HIGH, then re-enable with dead_time=3.
    set_dt(3, 3);
    pwm_in = 1'b1;
    tick(6);
    enable = 1'b0;
    tick(3);
    enable = 1'b1;
    tick(6);

    // Different rise/fall gaps (equal in the symmetric build).
    set_dt(2, 7);
    pwm_in = 1'b0;
    tick(10);
    pwm_in = 1'b1;
    tick(6);
    pwm_in = 1'b0;
    tick(10);

    // dt changed mid-gap must not affect the gap in progress.
    set_dt(6, 6);
    pwm_in = 1'b1;
    tick(2);
    set_dt(1, 1);
    tick(8);
    pwm_in = 1'b0;
    tick(4);

    // Largest dead time counts fully.
    set_dt(65535, 65535);
    pwm_in = 1'b1;
    tick(65540);
    set_dt(1, 1);
    pwm_in = 1'b0;
    tick(4);

    // Randomized run with occasional reset, disable and dt changes.
    for (int i = 0; i < 3000; i++) begin
      int r;
      r      = int'($urandom_range(0, 99));
      reset  = (r < 2);
      enable = (r >= 5);
      if ($urandom_range(0, 5) == 0) pwm_in = ~pwm_in;
      if ($urandom_range(0, 19) == 0)
        set_dt(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
      tick(1);
    end
    reset  = 1'b0;
    enable = 1'b1;
    tick(3);

    @(posedge clk);
    #2;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending, expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
